ssvep_stream_arbiter: RTL and testbench

Round-robin, burst-granting arbiter that shares one 32-bit Avalon-ST sink of the SSVEP processor subsystem among four upstream stream sources, e.g. per-electrode ADS1299 sample streams or lock-in results. It grants one source at a time for up to `BURST_LEN` words, rotates fairly between sources, and drives the shared sink through a registered output stage. The block sits between the acquisition/filter front-end and the processor's `fifo_N_in` / `datos_muestreados_in` stream sinks.

---
 rtl/ssvep_stream_pkg.sv | 19 +
 rtl/ssvep_stream_arbiter_if.sv | 25 ++
 rtl/ssvep_rr_pick.sv | 27 ++
 rtl/ssvep_stream_arbiter.sv | 118 +++++++++++
 tb/tb_ssvep_stream_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ssvep_stream_pkg.sv
// rtl/ssvep_stream_pkg.sv - shared types and constants for the four-source stream arbiter
package ssvep_stream_pkg;

    localparam int N_SRC = 4;
    localparam int TAG_W = 2;

    typedef logic [1:0] src_idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Lowest bit of the source-index tag placed in the top of the output word
    function automatic int tag_lsb(input int data_w);
        return data_w - TAG_W;
    endfunction

endpackage

// File: rtl/ssvep_stream_arbiter_if.sv
// rtl/ssvep_stream_arbiter_if.sv - source-side and sink-side stream signals of the arbiter
interface ssvep_stream_arbiter_if #(
    parameter int DATA_W = 32
);
    import ssvep_stream_pkg::*;

    logic [N_SRC-1:0]        src_valid;
    logic [N_SRC*DATA_W-1:0] src_data;
    logic [N_SRC-1:0]        src_ready;
    logic                    out_valid;
    logic [DATA_W-1:0]       out_data;
    logic                    out_ready;
    src_idx_t                out_channel;

    modport slave (
        input  src_valid, src_data, out_ready,
        output src_ready, out_valid, out_data, out_channel
    );

    modport master (
        output src_valid, src_data, out_ready,
        input  src_ready, out_valid, out_data, out_channel
    );

endinterface

// File: rtl/ssvep_rr_pick.sv
// rtl/ssvep_rr_pick.sv - combinational rotate-priority picker: first request at or after the pointer
module ssvep_rr_pick
    import ssvep_stream_pkg::*;
(
    input  logic [N_SRC-1:0] i_req,
    input  src_idx_t         i_ptr,
    output logic             o_hit,
    output src_idx_t         o_idx
);

    src_idx_t w_cand;

    // Scan from the farthest offset down so the nearest request is the one that sticks
    always_comb begin
        o_hit  = 1'b0;
        o_idx  = i_ptr;
        w_cand = i_ptr;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            w_cand = i_ptr + k[1:0];
            if (i_req[w_cand]) begin
                o_hit = 1'b1;
                o_idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/ssvep_stream_arbiter.sv
// rtl/ssvep_stream_arbiter.sv - round-robin burst arbiter, four sources onto one registered sink
// Optional macro SSVEP_STREAM_ARB_TAG_EN: overwrite the two top output bits with the source index.
module ssvep_stream_arbiter
    import ssvep_stream_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 8
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,
    ssvep_stream_arbiter_if.slave  bus,
    output logic                   grant_active
);

    arb_state_t        r_state, w_state_nxt;
    src_idx_t          r_ptr, w_ptr_nxt;
    src_idx_t          r_grant, w_grant_nxt;
    logic [7:0]        r_count, w_count_nxt;
    logic              r_out_valid, w_out_valid_nxt;
    logic [DATA_W-1:0] r_out_data, w_out_data_nxt;
    src_idx_t          r_out_channel, w_out_channel_nxt;

    logic              w_hit;
    src_idx_t          w_pick_idx;
    logic              w_rdy;
    logic              w_xfer;
    logic [N_SRC-1:0]  w_src_ready;
    logic [DATA_W-1:0] w_src_word;
    logic [DATA_W-1:0] w_word;

    ssvep_rr_pick u_pick (
        .i_req (bus.src_valid),
        .i_ptr (r_ptr),
        .o_hit (w_hit),
        .o_idx (w_pick_idx)
    );

    assign w_src_word = bus.src_data[r_grant*DATA_W +: DATA_W];

`ifdef SSVEP_STREAM_ARB_TAG_EN
    assign w_word = {r_grant, w_src_word[tag_lsb(DATA_W)-1:0]};
`else
    assign w_word = w_src_word;
`endif

    always_comb begin
        w_state_nxt       = r_state;
        w_ptr_nxt         = r_ptr;
        w_grant_nxt       = r_grant;
        w_count_nxt       = r_count;
        w_out_valid_nxt   = r_out_valid;
        w_out_data_nxt    = r_out_data;
        w_out_channel_nxt = r_out_channel;
        w_src_ready       = '0;
        w_rdy             = 1'b0;
        w_xfer            = 1'b0;

        if (r_out_valid && bus.out_ready)
            w_out_valid_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    w_state_nxt = BURST;
                    w_grant_nxt = w_pick_idx;
                    w_count_nxt = 8'd0;
                end
            end
            BURST: begin
                w_rdy                = ~r_out_valid | bus.out_ready;
                w_src_ready[r_grant] = w_rdy;
                w_xfer               = bus.src_valid[r_grant] & w_rdy;
                if (w_xfer) begin
                    w_count_nxt       = r_count + 8'd1;
                    w_out_valid_nxt   = 1'b1;
                    w_out_data_nxt    = w_word;
                    w_out_channel_nxt = r_grant;
                    if (r_count == 8'(BURST_LEN - 1)) begin
                        w_state_nxt = IDLE;
                        w_ptr_nxt   = r_grant + 2'd1;
                    end
                end else if (w_rdy) begin
                    // A source that goes quiet while it could send gives up its grant
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = r_grant + 2'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_grant       <= '0;
            r_count       <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_channel <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_grant       <= w_grant_nxt;
            r_count       <= w_count_nxt;
            r_out_valid   <= w_out_valid_nxt;
            r_out_data    <= w_out_data_nxt;
            r_out_channel <= w_out_channel_nxt;
        end
    end

    assign bus.src_ready   = w_src_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_data    = r_out_data;
    assign bus.out_channel = r_out_channel;
    assign grant_active    = (r_state == BURST);

endmodule

// File: tb/tb_ssvep_stream_arbiter.sv
// tb/tb_ssvep_stream_arbiter.sv - directed self-checking bench for ssvep_stream_arbiter
module tb_ssvep_stream_arbiter;
    import ssvep_stream_pkg::*;

    localparam int DW = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   sv;
    logic         ordy;
    logic [31:0]  base [4];
    logic [31:0]  wcnt [4];
    logic [127:0] sdata;
    logic         use4;
    logic         ga8, ga4;
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    ssvep_stream_arbiter_if #(.DATA_W(DW)) i8 ();
    ssvep_stream_arbiter_if #(.DATA_W(DW)) i4 ();

    assign i8.src_valid = sv;
    assign i8.src_data  = sdata;
    assign i8.out_ready = ordy;
    assign i4.src_valid = sv;
    assign i4.src_data  = sdata;
    assign i4.out_ready = ordy;

    always_comb begin
        sdata = '0;
        for (int i = 0; i < 4; i++)
            sdata[i*32 +: 32] = base[i] + wcnt[i];
    end

    ssvep_stream_arbiter #(.DATA_W(DW), .BURST_LEN(8)) u_dut8 (
        .clk_clk      (clk),
        .reset_reset  (rst),
        .bus          (i8),
        .grant_active (ga8)
    );

    ssvep_stream_arbiter #(.DATA_W(DW), .BURST_LEN(4)) u_dut4 (
        .clk_clk      (clk),
        .reset_reset  (rst),
        .bus          (i4),
        .grant_active (ga4)
    );

    // One clock: note handshakes just before the edge, advance those sources after it
    task automatic step();
        logic [3:0] hs;
        @(negedge clk);
        hs = use4 ? (i4.src_valid & i4.src_ready) : (i8.src_valid & i8.src_ready);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (hs[i]) wcnt[i] = wcnt[i] + 32'd1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        sv   = 4'b0000;
        ordy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wcnt[i] = 32'd0;
            base[i] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            step();
            total++;
            if (i8.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid cyc=%0d got=%b exp=0", c, i8.out_valid); end
            total++;
            if (i8.src_ready !== 4'b0000) begin bad++; $display("FAIL reset_src_ready cyc=%0d got=%b exp=0000", c, i8.src_ready); end
            total++;
            if (ga8 !== 1'b0) begin bad++; $display("FAIL reset_grant cyc=%0d got=%b exp=0", c, ga8); end
        end
        base[2] = 32'h100;
        sv = 4'b0100;
        repeat (3) step();
        total++;
        if (ga8 !== 1'b1 || i8.out_valid !== 1'b1) begin bad++; $display("FAIL midburst_setup got ga=%b v=%b exp ga=1 v=1", ga8, i8.out_valid); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (i8.out_valid !== 1'b0 || i8.out_data !== 32'h0 || i8.out_channel !== 2'd0)
            begin bad++; $display("FAIL midburst_out got v=%b d=%h ch=%0d exp v=0 d=0 ch=0", i8.out_valid, i8.out_data, i8.out_channel); end
        total++;
        if (i8.src_ready !== 4'b0000 || ga8 !== 1'b0)
            begin bad++; $display("FAIL midburst_ctrl got rdy=%b ga=%b exp rdy=0000 ga=0", i8.src_ready, ga8); end
        sv = 4'b0000;
    endtask

    task automatic test_single_source();
        logic        ev, eg;
        logic [31:0] ed;
        do_reset();
        base[2] = 32'h100;
        sv = 4'b0100;
        for (int c = 1; c <= 18; c++) begin
            step();
            ev = !(c == 1 || c == 10);
            eg = !(c == 9 || c == 18);
            ed = 32'h100 + ((c < 10) ? c - 2 : c - 3);
            total++;
            if (i8.out_valid !== ev) begin bad++; $display("FAIL single_valid cyc=%0d got=%b exp=%b", c, i8.out_valid, ev); end
            total++;
            if (ga8 !== eg) begin bad++; $display("FAIL single_grant cyc=%0d got=%b exp=%b", c, ga8, eg); end
            if (ev) begin
                total++;
                if (i8.out_data !== ed || i8.out_channel !== 2'd2)
                    begin bad++; $display("FAIL single_word cyc=%0d got=%h/%0d exp=%h/2", c, i8.out_data, i8.out_channel, ed); end
            end
        end
        sv = 4'b0000;
    endtask

    task automatic test_round_robin();
        int          n, first, last, k, j, src;
        logic        ev;
        logic [31:0] ed;
        logic [1:0]  ech;
        use4 = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) base[i] = 32'(i) << 8;
        sv = 4'b1111;
        n = 0; first = -1; last = -1;
        for (int c = 1; c <= 25; c++) begin
            step();
            ev = ((c - 1) % 5) != 0;
            total++;
            if (i4.out_valid !== ev) begin bad++; $display("FAIL rr_valid cyc=%0d got=%b exp=%b", c, i4.out_valid, ev); end
            if (i4.out_valid === 1'b1) begin
                k = n / 4; j = n % 4; src = k % 4;
                ed  = 32'(src * 256 + (k / 4) * 4 + j);
                ech = src[1:0];
                total++;
                if (i4.out_data !== ed || i4.out_channel !== ech)
                    begin bad++; $display("FAIL rr_word n=%0d got=%h/%0d exp=%h/%0d", n, i4.out_data, i4.out_channel, ed, ech); end
                if (first < 0) first = c;
                last = c;
                n++;
            end
        end
        total++;
        if (n != 20) begin bad++; $display("FAIL rr_words got=%0d exp=20", n); end
        total++;
        if (last - first + 1 != 24) begin bad++; $display("FAIL rr_span got=%0d exp=24", last - first + 1); end
        sv = 4'b0000;
        step();
        use4 = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        base[1] = 32'h500;
        sv = 4'b0010;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (i8.out_valid !== 1'b1 || i8.out_data !== 32'h500 + 32'(i))
                begin bad++; $display("FAIL bp_pre i=%0d got=%b/%h exp=1/%h", i, i8.out_valid, i8.out_data, 32'h500 + 32'(i)); end
        end
        ordy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (i8.out_valid !== 1'b1 || i8.out_data !== 32'h502)
                begin bad++; $display("FAIL bp_hold i=%0d got=%b/%h exp=1/00000502", i, i8.out_valid, i8.out_data); end
            total++;
            if (i8.src_ready !== 4'b0000 || ga8 !== 1'b1)
                begin bad++; $display("FAIL bp_ready i=%0d got rdy=%b ga=%b exp rdy=0000 ga=1", i, i8.src_ready, ga8); end
        end
        ordy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (i8.out_valid !== 1'b1 || i8.out_data !== 32'h503 + 32'(i))
                begin bad++; $display("FAIL bp_resume i=%0d got=%b/%h exp=1/%h", i, i8.out_valid, i8.out_data, 32'h503 + 32'(i)); end
        end
        total++;
        if (ga8 !== 1'b0) begin bad++; $display("FAIL bp_end got=%b exp=0", ga8); end
        step();
        total++;
        if (i8.out_valid !== 1'b0) begin bad++; $display("FAIL bp_idle_gap got=%b exp=0", i8.out_valid); end
        sv = 4'b0000;
    endtask

    task automatic test_gap();
        do_reset();
        base[1] = 32'h600;
        base[3] = 32'h700;
        sv = 4'b1010;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (i8.out_data !== 32'h600 + 32'(i) || i8.out_channel !== 2'd1)
                begin bad++; $display("FAIL gap_pre i=%0d got=%h/%0d exp=%h/1", i, i8.out_data, i8.out_channel, 32'h600 + 32'(i)); end
        end
        sv = 4'b1000;
        step();
        total++;
        if (ga8 !== 1'b0 || i8.out_valid !== 1'b0)
            begin bad++; $display("FAIL gap_end got ga=%b v=%b exp ga=0 v=0", ga8, i8.out_valid); end
        step();
        total++;
        if (ga8 !== 1'b1) begin bad++; $display("FAIL gap_regrant got=%b exp=1", ga8); end
        step();
        total++;
        if (i8.out_valid !== 1'b1 || i8.out_channel !== 2'd3 || i8.out_data !== 32'h700)
            begin bad++; $display("FAIL gap_next got=%b/%0d/%h exp=1/3/00000700", i8.out_valid, i8.out_channel, i8.out_data); end
        sv = 4'b0000;
    endtask

    task automatic test_tag();
        logic [31:0] exp_d;
`ifdef SSVEP_STREAM_ARB_TAG_EN
        exp_d = 32'hC000_00AA;
`else
        exp_d = 32'h0000_00AA;
`endif
        do_reset();
        base[3] = 32'hAA;
        sv = 4'b1000;
        step();
        step();
        total++;
        if (i8.out_valid !== 1'b1 || i8.out_data !== exp_d || i8.out_channel !== 2'd3)
            begin bad++; $display("FAIL tag got=%b/%h/%0d exp=1/%h/3", i8.out_valid, i8.out_data, i8.out_channel, exp_d); end
        sv = 4'b0000;
    endtask

    initial begin
        rst  = 1'b1;
        sv   = 4'b0000;
        ordy = 1'b1;
        use4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            base[i] = 32'd0;
            wcnt[i] = 32'd0;
        end
        test_reset();
        test_single_source();
        test_round_robin();
        test_backpressure();
        test_gap();
        test_tag();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
